// File: rtl/exe_muldiv_unit_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
// master: EXE side (drives request, cancel, resp_ready); slave: the unit.
// Ports: req_valid/req_ready/req_op/req_src1/req_src2, cancel, resp_valid/resp_ready/resp_hi/resp_lo/resp_dbz, busy.
interface exe_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_src1;
   logic [XLEN-1:0] req_src2;
   logic            cancel;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_hi;
   logic [XLEN-1:0] resp_lo;
   logic            resp_dbz;
   logic            busy;

   modport master (
      output req_valid, req_op, req_src1, req_src2, cancel, resp_ready,
      input  req_ready, resp_valid, resp_hi, resp_lo, resp_dbz, busy
   );

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, cancel, resp_ready,
      output req_ready, resp_valid, resp_hi, resp_lo, resp_dbz, busy
   );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for EXE; result {hi,lo} held until consumed, flushable by cancel.
// Latency: multiply MUL_LAT cycles accept->resp_valid; divide XLEN/DIV_BPC+2; divide-by-zero 3.
// Backpressure: result held while resp_ready=0; new request taken only in IDLE or in the consume cycle.
// Ports: clk, resetn (async active-low), bus (slave modport of exe_muldiv_unit_if: request handshake,
//        cancel, response handshake with hi/lo/dbz, busy).
module exe_muldiv_unit #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2,
   parameter int DIV_BPC = 1
) (
   input  logic              clk,
   input  logic              resetn,
   exe_muldiv_unit_if.slave  bus
);

   localparam int ITERS = XLEN / DIV_BPC;
   localparam int CW    = $clog2(ITERS + MUL_LAT + 1);
   localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] ITER_LAST = CW'(ITERS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL      = 3'd1,
      DIV_PRE  = 3'd2,
      DIV_ITER = 3'd3,
      DIV_FIX  = 3'd4,
      DONE     = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic            sgn_q, sgn_d;        // 1 = signed op (MULT/DIV)
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;       // dividend shifts out as quotient shifts in
   logic [XLEN-1:0] dvs_q, dvs_d;       // |divisor|
   logic            q_sign_q, q_sign_d;
   logic            r_sign_q, r_sign_d;
   logic            zero_q, zero_d;     // divisor was zero
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            dbz_q, dbz_d;

   logic req_ready;
   logic accept;

   assign req_ready = (state_q == IDLE) | ((state_q == DONE) & bus.resp_ready);
   assign accept    = bus.req_valid & req_ready & ~bus.cancel;

   // Multiplier: sign-extending both operands to 2*XLEN and keeping the low 2*XLEN
   // bits of the product gives the exact signed or unsigned full product.
   // Outside MUL it looks at the live request so MUL_LAT=1 can finish in one cycle.
   logic            mul_use_req;
   logic            mul_sgn;
   logic [XLEN-1:0] mul_a, mul_b;
   logic [2*XLEN-1:0] mul_ax, mul_bx, mul_p;

   assign mul_use_req = (state_q != MUL);
   assign mul_sgn     = mul_use_req ? ~bus.req_op[0] : sgn_q;
   assign mul_a       = mul_use_req ? bus.req_src1 : a_q;
   assign mul_b       = mul_use_req ? bus.req_src2 : b_q;
   assign mul_ax      = {{XLEN{mul_sgn & mul_a[XLEN-1]}}, mul_a};
   assign mul_bx      = {{XLEN{mul_sgn & mul_b[XLEN-1]}}, mul_b};
   assign mul_p       = mul_ax * mul_bx;

   // Divider operand preparation (used in DIV_PRE).
   logic            s1, s2;
   logic [XLEN-1:0] abs_a, abs_b;

   assign s1    = sgn_q & a_q[XLEN-1];
   assign s2    = sgn_q & b_q[XLEN-1];
   assign abs_a = s1 ? -a_q : a_q;
   assign abs_b = s2 ? -b_q : b_q;

   // Restoring shift-subtract, DIV_BPC quotient bits per cycle. DIV_PRE already
   // retires the first group straight from the absolute values, so DIV_ITER only
   // needs ITERS-1 cycles and accept->result stays ITERS+2.
   logic            step_pre;
   logic [XLEN-1:0] step_rin, step_qin, step_dvs;
   logic [XLEN-1:0] step_r, step_q;
   logic [XLEN:0]   trial;

   assign step_pre = (state_q == DIV_PRE);
   assign step_rin = step_pre ? '0    : rem_q;
   assign step_qin = step_pre ? abs_a : quo_q;
   assign step_dvs = step_pre ? abs_b : dvs_q;

   always_comb begin
      step_r = step_rin;
      step_q = step_qin;
      trial  = '0;
      for (int i = 0; i < DIV_BPC; i++) begin
         trial  = {step_r, step_q[XLEN-1]};
         step_q = {step_q[XLEN-2:0], 1'b0};
         if (trial >= {1'b0, step_dvs}) begin
            trial     = trial - {1'b0, step_dvs};
            step_q[0] = 1'b1;
         end
         step_r = trial[XLEN-1:0];
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      sgn_d    = sgn_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      q_sign_d = q_sign_q;
      r_sign_d = r_sign_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;

      case (state_q)
         IDLE: begin
         end
         MUL: begin
            if (cnt_q == MUL_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               hi_d    = mul_p[2*XLEN-1:XLEN];
               lo_d    = mul_p[XLEN-1:0];
               dbz_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIV_PRE: begin
            q_sign_d = s1 ^ s2;
            r_sign_d = s1;
            dvs_d    = abs_b;
            if (b_q == '0) begin
               zero_d  = 1'b1;
               cnt_d   = '0;
               state_d = DIV_FIX;
            end else begin
               zero_d  = 1'b0;
               rem_d   = step_r;
               quo_d   = step_q;
               cnt_d   = CW'(1);
               state_d = (ITERS == 1) ? DIV_FIX : DIV_ITER;
            end
         end
         DIV_ITER: begin
            rem_d = step_r;
            quo_d = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ITER_LAST) begin
               state_d = DIV_FIX;
            end
         end
         DIV_FIX: begin
            state_d = DONE;
            cnt_d   = '0;
            if (zero_q) begin
               // Divide by zero: dividend passes through untouched.
               hi_d  = a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d  = r_sign_q ? -rem_q : rem_q;
               lo_d  = q_sign_q ? -quo_q : quo_q;
               dbz_d = 1'b0;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
               dbz_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new request overrides the DONE->IDLE step so consume+accept has no bubble.
      if (accept) begin
         sgn_d = ~bus.req_op[0];
         a_d   = bus.req_src1;
         b_d   = bus.req_src2;
         dbz_d = 1'b0;
         if (bus.req_op[1]) begin
            cnt_d   = '0;
            state_d = DIV_PRE;
         end else if (MUL_LAT == 1) begin
            cnt_d   = '0;
            hi_d    = mul_p[2*XLEN-1:XLEN];
            lo_d    = mul_p[XLEN-1:0];
            state_d = DONE;
         end else begin
            cnt_d   = CW'(1);
            state_d = MUL;
         end
      end

      // Flush wins over everything; hi/lo are left as they were.
      if (bus.cancel) begin
         state_d = IDLE;
         cnt_d   = '0;
         dbz_d   = 1'b0;
         zero_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         sgn_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         q_sign_q <= 1'b0;
         r_sign_q <= 1'b0;
         zero_q   <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sgn_q    <= sgn_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         q_sign_q <= q_sign_d;
         r_sign_q <= r_sign_d;
         zero_q   <= zero_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp_hi    = hi_q;
   assign bus.resp_lo    = lo_q;
   assign bus.resp_dbz   = dbz_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Bench for exe_muldiv_unit: directed cases, hold/backpressure, cancel, back-to-back,
// random ops against an arithmetic reference model, and asynchronous reset mid-divide.
// Ports driven through an exe_muldiv_unit_if instance; clock period 10.
module tb_exe_muldiv_unit;

   localparam int XLEN    = 32;
   localparam int MUL_LAT = 2;
   localparam int DIV_BPC = 1;
   localparam int DIV_LAT = XLEN / DIV_BPC + 2;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   exe_muldiv_unit_if #(.XLEN(XLEN)) mif ();

   exe_muldiv_unit #(
      .XLEN    (XLEN),
      .MUL_LAT (MUL_LAT),
      .DIV_BPC (DIV_BPC)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (mif)
   );

   always #5 clk = ~clk;

   // Reference: {dbz, hi, lo} from plain 64-bit arithmetic.
   function automatic logic [2*XLEN:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      logic [2*XLEN:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = '0;
      if (op == 2'd0) begin
         sq  = sa * sb;
         res = {1'b0, sq};
      end else if (op == 2'd1) begin
         up  = ua * ub;
         res = {1'b0, up};
      end else if (b == 32'd0) begin
         res = {1'b1, a, 32'hFFFF_FFFF};
      end else if (op == 2'd2) begin
         sq  = sa / sb;
         sr  = sa % sb;
         res = {1'b0, sr[31:0], sq[31:0]};
      end else begin
         uq  = ua / ub;
         ur  = ua % ub;
         res = {1'b0, ur[31:0], uq[31:0]};
      end
      return res;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
      if (!op[1]) return MUL_LAT;
      if (b == 32'd0) return 3;
      return DIV_LAT;
   endfunction

   function automatic logic [31:0] rnd_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'($urandom_range(0, 15));
         default: v = $urandom();
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and wait for resp_valid; result is left held (not consumed).
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      int guard;
      guard = 0;
      while (mif.req_ready !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      mif.req_op    = op;
      mif.req_src1  = a;
      mif.req_src2  = b;
      mif.req_valid = 1'b1;
      tick();
      mif.req_valid = 1'b0;
      lat = 1;
      while (mif.resp_valid !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
      checks++;
      if (mif.resp_valid !== 1'b1) begin
         failures++;
         $display("FAIL op_timeout: resp_valid=%b required 1 (op=%0d a=%h b=%h)", mif.resp_valid, op, a, b);
      end
      hi  = mif.resp_hi;
      lo  = mif.resp_lo;
      dbz = mif.resp_dbz;
   endtask

   task automatic consume();
      mif.resp_ready = 1'b1;
      tick();
      mif.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      mif.req_valid = 1'b0; mif.req_op = 2'd0; mif.req_src1 = '0; mif.req_src2 = '0;
      mif.cancel = 1'b0; mif.resp_ready = 1'b0;
      resetn = 1'b0;
      repeat (2) tick();
      checks++; if (mif.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b required 1", mif.req_ready); end
      checks++; if (mif.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b required 0", mif.resp_valid); end
      checks++; if (mif.resp_hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h required 0", mif.resp_hi); end
      checks++; if (mif.resp_lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h required 0", mif.resp_lo); end
      checks++; if (mif.resp_dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b required 0", mif.resp_dbz); end
      checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", mif.busy); end
      resetn = 1'b1;
      tick();
      checks++; if (mif.busy !== 1'b0 || mif.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_idle: busy=%b req_ready=%b required 0/1", mif.busy, mif.req_ready); end
   endtask

   task automatic test_directed();
      int          lat;
      logic [31:0] hi, lo;
      logic        dbz;
      do_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, lat, hi, lo, dbz);
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || dbz !== 1'b0 || lat != MUL_LAT) begin
         failures++; $display("FAIL mult_neg: got hi=%h lo=%h dbz=%b lat=%0d required FFFFFFFF FFFFFFFA 0 %0d", hi, lo, dbz, lat, MUL_LAT); end
      consume();
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, hi, lo, dbz);
      checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || lat != MUL_LAT) begin
         failures++; $display("FAIL multu_max: got hi=%h lo=%h lat=%0d required FFFFFFFE 00000001 %0d", hi, lo, lat, MUL_LAT); end
      consume();
      do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, lat, hi, lo, dbz);
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD || dbz !== 1'b0 || lat != DIV_LAT) begin
         failures++; $display("FAIL div_neg7_2: got hi=%h lo=%h dbz=%b lat=%0d required FFFFFFFF FFFFFFFD 0 %0d", hi, lo, dbz, lat, DIV_LAT); end
      consume();
      do_op(2'd3, 32'd7, 32'd0, lat, hi, lo, dbz);
      checks++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF || dbz !== 1'b1 || lat != 3) begin
         failures++; $display("FAIL divu_by_zero: got hi=%h lo=%h dbz=%b lat=%0d required 7 FFFFFFFF 1 3", hi, lo, dbz, lat); end
      consume();
      checks++; if (mif.resp_dbz !== 1'b0 || mif.resp_valid !== 1'b0) begin
         failures++; $display("FAIL dbz_clear_on_consume: dbz=%b valid=%b required 0 0", mif.resp_dbz, mif.resp_valid); end
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, dbz);
      checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000 || dbz !== 1'b0) begin
         failures++; $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b required 0 80000000 0", hi, lo, dbz); end
      consume();
   endtask

   task automatic test_hold();
      int              lat;
      logic [31:0]     hi, lo, a, b, a2, b2;
      logic            dbz;
      logic [2*XLEN:0] e1, e2;
      a = $urandom(); b = $urandom(); a2 = $urandom(); b2 = $urandom();
      e1 = model(2'd0, a, b);
      e2 = model(2'd0, a2, b2);
      do_op(2'd0, a, b, lat, hi, lo, dbz);
      mif.req_op = 2'd0; mif.req_src1 = a2; mif.req_src2 = b2; mif.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (mif.resp_valid !== 1'b1 || {mif.resp_dbz, mif.resp_hi, mif.resp_lo} !== e1 || mif.req_ready !== 1'b0) begin
            failures++; $display("FAIL hold_stable[%0d]: valid=%b hi=%h lo=%h req_ready=%b required 1 %h %h 0",
                                 i, mif.resp_valid, mif.resp_hi, mif.resp_lo, mif.req_ready, e1[63:32], e1[31:0]); end
      end
      mif.resp_ready = 1'b1;
      #1;
      checks++; if (mif.req_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready: got %b required 1", mif.req_ready); end
      tick();
      mif.req_valid = 1'b0; mif.resp_ready = 1'b0;
      lat = 1;
      while (mif.resp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
      checks++; if ({mif.resp_dbz, mif.resp_hi, mif.resp_lo} !== e2 || lat != MUL_LAT) begin
         failures++; $display("FAIL hold_next_mult: got hi=%h lo=%h lat=%0d required %h %h %0d", mif.resp_hi, mif.resp_lo, lat, e2[63:32], e2[31:0], MUL_LAT); end
      consume();
   endtask

   task automatic test_cancel();
      int          lat, seen;
      logic [31:0] hi, lo;
      logic        dbz;
      // Cancel while idle: nothing changes.
      mif.cancel = 1'b1;
      tick();
      mif.cancel = 1'b0;
      checks++; if (mif.busy !== 1'b0 || mif.req_ready !== 1'b1) begin failures++; $display("FAIL cancel_idle: busy=%b req_ready=%b required 0 1", mif.busy, mif.req_ready); end
      // Cancel at iteration 10 of a DIV with a competing request.
      mif.req_op = 2'd2; mif.req_src1 = 32'h1234_5678; mif.req_src2 = 32'd9; mif.req_valid = 1'b1;
      tick();
      mif.req_valid = 1'b0;
      repeat (10) tick();
      mif.cancel = 1'b1; mif.req_valid = 1'b1; mif.req_op = 2'd1; mif.req_src1 = 32'd5; mif.req_src2 = 32'd6;
      tick();
      mif.cancel = 1'b0; mif.req_valid = 1'b0;
      checks++; if (mif.busy !== 1'b0 || mif.resp_valid !== 1'b0 || mif.req_ready !== 1'b1) begin
         failures++; $display("FAIL cancel_div: busy=%b valid=%b req_ready=%b required 0 0 1", mif.busy, mif.resp_valid, mif.req_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (mif.resp_valid === 1'b1 || mif.busy === 1'b1) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL cancel_no_resp: active cycles=%0d required 0", seen); end
      do_op(2'd3, 32'd100, 32'd7, lat, hi, lo, dbz);
      checks++; if (lo !== 32'd14 || hi !== 32'd2 || lat != DIV_LAT) begin
         failures++; $display("FAIL divu_100_7: got lo=%0d hi=%0d lat=%0d required 14 2 %0d", lo, hi, lat, DIV_LAT); end
      consume();
      // Cancel together with resp_ready and a request in DONE: result dropped, request refused.
      do_op(2'd2, 32'd55, 32'd0, lat, hi, lo, dbz);
      mif.cancel = 1'b1; mif.resp_ready = 1'b1; mif.req_valid = 1'b1; mif.req_op = 2'd0;
      tick();
      mif.cancel = 1'b0; mif.resp_ready = 1'b0; mif.req_valid = 1'b0;
      checks++; if (mif.resp_valid !== 1'b0 || mif.resp_dbz !== 1'b0 || mif.busy !== 1'b0) begin
         failures++; $display("FAIL cancel_done: valid=%b dbz=%b busy=%b required 0 0 0", mif.resp_valid, mif.resp_dbz, mif.busy); end
   endtask

   task automatic test_back_to_back();
      int              lat;
      logic [1:0]      op;
      logic [31:0]     a, b, hi, lo;
      logic            dbz;
      logic [2*XLEN:0] e;
      op = 2'($urandom_range(0, 3)); a = rnd_operand(); b = rnd_operand();
      do_op(op, a, b, lat, hi, lo, dbz);
      for (int j = 0; j < 20; j++) begin
         e = model(op, a, b);
         checks++; if ({mif.resp_dbz, mif.resp_hi, mif.resp_lo} !== e || lat != exp_lat(op, b)) begin
            failures++; $display("FAIL b2b[%0d]: op=%0d a=%h b=%h got %b/%h/%h lat=%0d required %b/%h/%h lat=%0d",
                                 j, op, a, b, mif.resp_dbz, mif.resp_hi, mif.resp_lo, lat, e[64], e[63:32], e[31:0], exp_lat(op, b)); end
         op = 2'($urandom_range(0, 3)); a = rnd_operand(); b = rnd_operand();
         mif.req_op = op; mif.req_src1 = a; mif.req_src2 = b; mif.req_valid = 1'b1; mif.resp_ready = 1'b1;
         #1;
         checks++; if (mif.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b required 1", j, mif.req_ready); end
         tick();
         mif.req_valid = 1'b0; mif.resp_ready = 1'b0;
         lat = 1;
         while (mif.resp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
      end
      consume();
   endtask

   task automatic test_random();
      int              lat, gap;
      logic [1:0]      op;
      logic [31:0]     a, b, hi, lo;
      logic            dbz;
      logic [2*XLEN:0] e;
      for (int i = 0; i < 400; i++) begin
         op = 2'($urandom_range(0, 3)); a = rnd_operand(); b = rnd_operand();
         e = model(op, a, b);
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
         do_op(op, a, b, lat, hi, lo, dbz);
         checks++; if ({dbz, hi, lo} !== e || lat != exp_lat(op, b)) begin
            failures++; $display("FAIL rand[%0d]: op=%0d a=%h b=%h got %b/%h/%h lat=%0d required %b/%h/%h lat=%0d",
                                 i, op, a, b, dbz, hi, lo, lat, e[64], e[63:32], e[31:0], exp_lat(op, b)); end
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
         checks++; if (mif.resp_valid !== 1'b1 || {mif.resp_dbz, mif.resp_hi, mif.resp_lo} !== e) begin
            failures++; $display("FAIL rand_hold[%0d]: valid=%b hi=%h lo=%h required 1 %h %h", i, mif.resp_valid, mif.resp_hi, mif.resp_lo, e[63:32], e[31:0]); end
         consume();
         checks++; if (mif.resp_valid !== 1'b0) begin failures++; $display("FAIL rand_drop[%0d]: resp_valid=%b required 0", i, mif.resp_valid); end
      end
   endtask

   task automatic test_reset_mid();
      int              lat;
      logic [31:0]     hi, lo;
      logic            dbz;
      logic [2*XLEN:0] e;
      do_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, lat, hi, lo, dbz);
      consume();
      mif.req_op = 2'd2; mif.req_src1 = 32'hF000_0001; mif.req_src2 = 32'd3; mif.req_valid = 1'b1;
      tick();
      mif.req_valid = 1'b0;
      repeat (7) tick();
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (mif.req_ready !== 1'b1 || mif.resp_valid !== 1'b0 || mif.busy !== 1'b0 ||
                    mif.resp_hi !== 32'd0 || mif.resp_lo !== 32'd0 || mif.resp_dbz !== 1'b0) begin
         failures++; $display("FAIL reset_mid_div: ready=%b valid=%b busy=%b hi=%h lo=%h dbz=%b required 1 0 0 0 0 0",
                              mif.req_ready, mif.resp_valid, mif.busy, mif.resp_hi, mif.resp_lo, mif.resp_dbz); end
      @(negedge clk);
      resetn = 1'b1;
      tick();
      e = model(2'd2, 32'hF000_0001, 32'd3);
      do_op(2'd2, 32'hF000_0001, 32'd3, lat, hi, lo, dbz);
      checks++; if ({dbz, hi, lo} !== e) begin
         failures++; $display("FAIL after_reset_div: got %h/%h required %h/%h", hi, lo, e[63:32], e[31:0]); end
      consume();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_cancel();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
